// File: rtl/img_buf_ctrl.sv
`default_nettype none
// img_buf_ctrl: single-owner sequencer for the single-port image RAM (frame load, window read stream).
// Optional frame clear (clr_start, CLEAR state) is enabled by defining IMG_BUF_CTRL_CLEAR_EN.
module img_buf_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH_X      = 300,
   parameter int DEPTH_Y      = 300,
   parameter int ADDR_WIDTH_X = $clog2(DEPTH_X),
   parameter int ADDR_WIDTH_Y = $clog2(DEPTH_Y)
) (
   input  logic                           clk,
   input  logic                           rst,
`ifdef IMG_BUF_CTRL_CLEAR_EN
   input  logic                           clr_start,
`endif
   input  logic                           load_start,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           rd_start,
   input  logic [ADDR_WIDTH_X-1:0]        rd_x0,
   input  logic [ADDR_WIDTH_Y-1:0]        rd_y0,
   input  logic [ADDR_WIDTH_X:0]          rd_w,
   input  logic [ADDR_WIDTH_Y:0]          rd_h,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done,
   output logic                           cmd_err,
   output logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]          ram_wr_data,
   input  logic [DATA_WIDTH-1:0]          ram_rd_data,
   output logic                           ram_cs,
   output logic                           ram_we
);

   localparam logic [ADDR_WIDTH_X-1:0] X_MAX = ADDR_WIDTH_X'(DEPTH_X - 1);
   localparam logic [ADDR_WIDTH_Y-1:0] Y_MAX = ADDR_WIDTH_Y'(DEPTH_Y - 1);
   localparam logic [ADDR_WIDTH_X+1:0] X_LIM = (ADDR_WIDTH_X + 2)'(DEPTH_X);
   localparam logic [ADDR_WIDTH_Y+1:0] Y_LIM = (ADDR_WIDTH_Y + 2)'(DEPTH_Y);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_READ  = 3'd2,
`ifdef IMG_BUF_CTRL_CLEAR_EN
      S_CLEAR = 3'd4,
`endif
      S_DRAIN = 3'd3
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH_X-1:0] x_q, x0_q, xend_q;
   logic [ADDR_WIDTH_Y-1:0] y_q, yend_q;
   logic                    out_valid_q, out_last_q, done_q, cmd_err_q;

   // Window bounds are summed two bits wider than the origin so nothing wraps.
   logic [ADDR_WIDTH_X+1:0] x_sum_d, x_end_d;
   logic [ADDR_WIDTH_Y+1:0] y_sum_d, y_end_d;
   logic                    cmd_ok_d, wr_fire_d, rd_issue_d, at_end_d;

   assign x_sum_d  = {2'b00, rd_x0} + {1'b0, rd_w};
   assign y_sum_d  = {2'b00, rd_y0} + {1'b0, rd_h};
   assign x_end_d  = x_sum_d - (ADDR_WIDTH_X + 2)'(1);
   assign y_end_d  = y_sum_d - (ADDR_WIDTH_Y + 2)'(1);
   assign cmd_ok_d = (rd_w != '0) && (rd_h != '0) && (x_sum_d <= X_LIM) && (y_sum_d <= Y_LIM);

`ifdef IMG_BUF_CTRL_CLEAR_EN
   assign wr_fire_d = ((state_q == S_LOAD) && in_valid) || (state_q == S_CLEAR);
`else
   assign wr_fire_d = (state_q == S_LOAD) && in_valid;
`endif
   assign rd_issue_d = (state_q == S_READ) && (!out_valid_q || out_ready);
   assign at_end_d   = (x_q == xend_q) && (y_q == yend_q);

   assign in_ready    = (state_q == S_LOAD);
   assign ram_cs      = wr_fire_d || rd_issue_d;
   assign ram_we      = wr_fire_d;
   assign ram_addr    = {y_q, x_q};
   assign ram_wr_data = (state_q == S_LOAD) ? in_data : '0;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign out_data    = ram_rd_data;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign cmd_err     = cmd_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         x0_q        <= '0;
         xend_q      <= '0;
         yend_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cmd_err_q <= 1'b0;

         if (rd_issue_d) begin
            out_valid_q <= 1'b1;
            out_last_q  <= at_end_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
`ifdef IMG_BUF_CTRL_CLEAR_EN
               if (clr_start) begin
                  state_q <= S_CLEAR;
                  x_q     <= '0;
                  y_q     <= '0;
               end else
`endif
               if (load_start) begin
                  state_q <= S_LOAD;
                  x_q     <= '0;
                  y_q     <= '0;
               end else if (rd_start) begin
                  if (cmd_ok_d) begin
                     state_q <= S_READ;
                     x_q     <= rd_x0;
                     y_q     <= rd_y0;
                     x0_q    <= rd_x0;
                     xend_q  <= x_end_d[ADDR_WIDTH_X-1:0];
                     yend_q  <= y_end_d[ADDR_WIDTH_Y-1:0];
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
`ifdef IMG_BUF_CTRL_CLEAR_EN
            S_LOAD, S_CLEAR: begin
`else
            S_LOAD: begin
`endif
               if (wr_fire_d) begin
                  if (x_q == X_MAX) begin
                     x_q <= '0;
                     if (y_q == Y_MAX) begin
                        y_q     <= '0;
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                     end else begin
                        y_q <= y_q + ADDR_WIDTH_Y'(1);
                     end
                  end else begin
                     x_q <= x_q + ADDR_WIDTH_X'(1);
                  end
               end
            end
            S_READ: begin
               if (rd_issue_d) begin
                  if (x_q == xend_q) begin
                     x_q <= x0_q;
                     if (y_q == yend_q) state_q <= S_DRAIN;
                     else               y_q     <= y_q + ADDR_WIDTH_Y'(1);
                  end else begin
                     x_q <= x_q + ADDR_WIDTH_X'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (out_valid_q && out_ready) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                  x_q     <= '0;
                  y_q     <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_img_buf_ctrl.sv
`default_nettype none
// tb_img_buf_ctrl: directed + randomized checks of img_buf_ctrl against a frame/window reference model.
// A reduced 40x30 frame keeps the full-frame load and clear short.
module tb_img_buf_ctrl;

   localparam int DW    = 8;
   localparam int DX    = 40;
   localparam int DY    = 30;
   localparam int AX    = $clog2(DX);
   localparam int AY    = $clog2(DY);
   localparam int TOTAL = DX * DY;

   logic            clk = 1'b0;
   logic            rst;
`ifdef IMG_BUF_CTRL_CLEAR_EN
   logic            clr_start;
`endif
   logic            load_start, in_valid, in_ready;
   logic [DW-1:0]   in_data;
   logic            rd_start;
   logic [AX-1:0]   rd_x0;
   logic [AY-1:0]   rd_y0;
   logic [AX:0]     rd_w;
   logic [AY:0]     rd_h;
   logic            out_valid, out_ready, out_last;
   logic [DW-1:0]   out_data;
   logic            busy, done, cmd_err;
   logic [AX+AY-1:0] ram_addr;
   logic [DW-1:0]   ram_wr_data, ram_rd_data;
   logic            ram_cs, ram_we;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DW-1:0] mem     [0:(1<<(AX+AY))-1];
   logic [DW-1:0] ref_img [0:TOTAL-1];

   always #5 clk = ~clk;

   img_buf_ctrl #(
      .DATA_WIDTH(DW), .DEPTH_X(DX), .DEPTH_Y(DY), .ADDR_WIDTH_X(AX), .ADDR_WIDTH_Y(AY)
   ) dut (
      .clk(clk), .rst(rst),
`ifdef IMG_BUF_CTRL_CLEAR_EN
      .clr_start(clr_start),
`endif
      .load_start(load_start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rd_start(rd_start), .rd_x0(rd_x0), .rd_y0(rd_y0), .rd_w(rd_w), .rd_h(rd_h),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .cmd_err(cmd_err),
      .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
      .ram_cs(ram_cs), .ram_we(ram_we)
   );

   // Single-port RAM with registered read; read data holds when not selected.
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) mem[ram_addr] <= ram_wr_data;
         else        ram_rd_data   <= mem[ram_addr];
      end
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] pat(input int idx);
      return DW'(idx & 255);
   endfunction

   function automatic logic [31:0] addr_of(input int x, input int y);
      return (y << AX) | x;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame();
      int idx, writes, bad, dones, c;
      logic [31:0] last_addr;
      idx = 0; writes = 0; bad = 0; dones = 0; last_addr = '1;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (c = 0; c < 10 * TOTAL && idx < TOTAL; c++) begin
         in_valid = ($urandom_range(3) != 0);
         in_data  = pat(idx);
         @(negedge clk);
         if (c == 0) begin
            check("load_busy", busy, 1);
            check("load_in_ready", in_ready, 1);
         end
         if (done) dones++;
         if (ram_cs) begin
            writes++;
            last_addr = 32'(ram_addr);
            if (ram_we !== 1'b1 || 32'(ram_addr) !== addr_of(idx % DX, idx / DX) ||
                ram_wr_data !== pat(idx)) bad++;
         end
         if (in_valid && in_ready) idx++;
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("load_pixels", idx, TOTAL);
      check("load_writes", writes, TOTAL);
      check("load_bad_writes", bad, 0);
      check("load_last_addr", last_addr, addr_of(DX - 1, DY - 1));
      check("load_done", done, 1);
      check("load_busy_fall", busy, 0);
      check("load_early_done", dones, 0);
      step();
      @(negedge clk);
      check("load_done_pulse", done, 0);
      step();
      for (int i = 0; i < TOTAL; i++) ref_img[i] = pat(i);
   endtask

   // mode 0: out_ready high, 1: toggling, 2: random
   task automatic run_window(input int x0, input int y0, input int w, input int h,
                             input int mode, input string tag);
      logic [DW-1:0] expq[$];
      int n, k, reads, vcyc, bad, stallv, c;
      logic pstall, plast;
      logic [DW-1:0] pdata;
      for (int yy = y0; yy < y0 + h; yy++)
         for (int xx = x0; xx < x0 + w; xx++)
            expq.push_back(ref_img[yy * DX + xx]);
      n = expq.size(); k = 0; reads = 0; vcyc = 0; bad = 0; stallv = 0; c = 0;
      pstall = 1'b0; plast = 1'b0; pdata = '0;
      rd_x0 = AX'(x0); rd_y0 = AY'(y0); rd_w = (AX+1)'(w); rd_h = (AY+1)'(h);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      while (k < n && c < 20 * n + 20) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 2 == 0);
            default: out_ready = ($urandom_range(1) == 1);
         endcase
         @(negedge clk);
         if (c == 0) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_first_cs"}, ram_cs, 1);
         end
         if (ram_cs) begin
            reads++;
            if (ram_we !== 1'b0) bad++;
         end
         if (out_valid) vcyc++;
         if (pstall && (out_valid !== 1'b1 || out_data !== pdata || out_last !== plast)) stallv++;
         if (out_valid && !out_ready && ram_cs) stallv++;
         if (out_valid && out_ready) begin
            if (out_data !== expq[k] || out_last !== (k == n - 1)) bad++;
            k++;
         end
         pstall = out_valid && !out_ready;
         pdata  = out_data;
         plast  = out_last;
         c++;
         step();
      end
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_count"}, k, n);
      check({tag, "_data"}, bad, 0);
      check({tag, "_reads"}, reads, n);
      check({tag, "_stall"}, stallv, 0);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_fall"}, busy, 0);
      if (mode == 0) begin
         check({tag, "_valid_cycles"}, vcyc, n);
         check({tag, "_latency"}, c, n + 1);
      end
      step();
   endtask

   task automatic reject(input int x0, input int y0, input int w, input int h, input string tag);
      rd_x0 = AX'(x0); rd_y0 = AY'(y0); rd_w = (AX+1)'(w); rd_h = (AY+1)'(h);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      @(negedge clk);
      check({tag, "_cmd_err"}, cmd_err, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_cs"}, ram_cs, 0);
      step();
      @(negedge clk);
      check({tag, "_cmd_err_pulse"}, cmd_err, 0);
      check({tag, "_cs2"}, ram_cs, 0);
      step();
   endtask

   initial begin
      rst = 1'b1;
`ifdef IMG_BUF_CTRL_CLEAR_EN
      clr_start = 1'b0;
`endif
      load_start = 1'b0; in_valid = 1'b0; in_data = '0; rd_start = 1'b0;
      rd_x0 = '0; rd_y0 = '0; rd_w = '0; rd_h = '0; out_ready = 1'b0;
      step();
      step();
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmd_err", cmd_err, 0);
      check("rst_cs", ram_cs, 0);
      check("rst_we", ram_we, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wr_data", ram_wr_data, 0);
      rst = 1'b0;
      step();

      load_frame();
      run_window(10, 20, 3, 2, 0, "win_hi");
      run_window(10, 20, 3, 2, 1, "win_tog");
      reject(DX - 2, 0, 3, 1, "rej_x");
      reject(0, 0, 0, 1, "rej_w0");
      reject(0, DY - 1, 1, 2, "rej_y");
      run_window(DX - 3, DY - 2, 3, 2, 2, "win_corner");
      run_window(5, 5, 1, 1, 0, "win_1px");
      for (int i = 0; i < 4; i++) begin
         int x0, y0, w, h;
         x0 = $urandom_range(DX - 1);
         y0 = $urandom_range(DY - 1);
         w  = $urandom_range(DX - x0, 1);
         h  = $urandom_range(DY - y0, 1);
         run_window(x0, y0, w, h, 2, "win_rand");
      end

      // Reset in the middle of a stalled read.
      rd_x0 = AX'(2); rd_y0 = AY'(3); rd_w = (AX+1)'(8); rd_h = (AY+1)'(4);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_out_last", out_last, 0);
      check("arst_cs", ram_cs, 0);
      check("arst_addr", ram_addr, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      run_window(10, 20, 3, 2, 0, "win_after_rst");

      // Simultaneous starts: load takes the RAM.
      rd_x0 = '0; rd_y0 = '0; rd_w = (AX+1)'(2); rd_h = (AY+1)'(2);
      load_start = 1'b1;
      rd_start   = 1'b1;
      step();
      load_start = 1'b0;
      rd_start   = 1'b0;
      @(negedge clk);
      check("both_in_ready", in_ready, 1);
      check("both_busy", busy, 1);
      check("both_no_read", ram_cs, 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      @(negedge clk);
      rst = 1'b0;
      step();

`ifdef IMG_BUF_CTRL_CLEAR_EN
      begin
         int writes, bad;
         logic seen;
         writes = 0; bad = 0; seen = 1'b0;
         clr_start = 1'b1;
         step();
         clr_start = 1'b0;
         for (int c = 0; c < TOTAL + 10 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (ram_cs) begin
               if (ram_we !== 1'b1 || ram_wr_data !== '0 ||
                   32'(ram_addr) !== addr_of(writes % DX, writes / DX)) bad++;
               writes++;
            end
            step();
         end
         check("clr_done", seen, 1);
         check("clr_writes", writes, TOTAL);
         check("clr_bad", bad, 0);
         for (int i = 0; i < TOTAL; i++) ref_img[i] = '0;
         run_window(0, 0, DX, DY, 2, "win_clr");
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
